core_prefetch_unit: RTL and testbench

// - Parametrised instruction prefetcher for the fetch stage. It issues in-order AXI-lite reads

---
 rtl/core_prefetch_unit.sv | 163 ++++++++++++++++
 tb/tb_core_prefetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_prefetch_unit.sv
// In-order AXI-lite instruction prefetcher with a PC-tagged buffer.
// Branches flush the buffer and discard any reads still in flight.
module core_prefetch_unit #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    INSTR_WIDTH     = 32,
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
    parameter bit                    WORD_ADDR       = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_stall,
    input  logic                   is_branch,
    input  logic [ADDR_WIDTH-1:0]  new_pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_valid,
    output logic                   instr_err,
    output logic [ADDR_WIDTH-1:0]  ARADDR,
    output logic                   ARVALID,
    input  logic                   ARREADY,
    input  logic [DATA_WIDTH-1:0]  RDATA,
    input  logic [1:0]             RRESP,
    input  logic                   RVALID,
    output logic                   RREADY
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 2);

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_resp_pc;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_arvalid;
    logic                  r_rready;
    logic [CW-1:0]         r_out;
    logic [CW-1:0]         r_discard;
    logic [PW:0]           r_wptr;
    logic [PW:0]           r_rptr;

    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_pc   [FIFO_DEPTH];
    logic                  r_mem_err  [FIFO_DEPTH];

    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic [PW:0]           w_count;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_out_next;
    logic [CW:0]           w_used;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_tgt;
    logic [ADDR_WIDTH-1:0] w_fetch_addr;
    logic [PW-1:0]         w_widx;
    logic [PW-1:0]         w_ridx;

    assign w_ar_hs    = r_arvalid & ARREADY;
    assign w_r_hs     = RVALID & r_rready;
    assign w_count    = r_wptr - r_rptr;
    assign w_widx     = r_wptr[PW-1:0];
    assign w_ridx     = r_rptr[PW-1:0];
    assign w_push     = w_r_hs && (r_discard == '0) && !is_branch;
    assign w_pop      = instr_valid && !fetch_stall && !is_branch;
    assign w_out_next = r_out + CW'(w_ar_hs) - CW'(w_r_hs);
    assign w_used     = {1'b0, r_out} + (CW+1)'(w_count);
    assign w_tgt      = {new_pc[ADDR_WIDTH-1:2], 2'b00};

    // Every in-flight read holds a reserved buffer slot, so RREADY can stay high.
    assign w_issue = !r_arvalid && !is_branch
                   && (w_used < (CW+1)'(FIFO_DEPTH))
                   && (r_out < CW'(MAX_OUTSTANDING));

    assign w_fetch_addr = WORD_ADDR ? {2'b00, r_fetch_pc[ADDR_WIDTH-1:2]}
                                    : r_fetch_pc;

    assign ARADDR      = r_araddr;
    assign ARVALID     = r_arvalid;
    assign RREADY      = r_rready;
    assign instr_valid = (w_count != '0);

    // AR channel: address is latched at raise time and held until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_fetch_pc <= RESET_PC;
        end else begin
            if (w_issue) begin
                r_arvalid  <= 1'b1;
                r_araddr   <= w_fetch_addr;
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
            end else if (w_ar_hs) begin
                r_arvalid  <= 1'b0;
            end
            if (is_branch) begin
                r_fetch_pc <= w_tgt;
            end
        end
    end

    // Outstanding / discard accounting and response PC tagging.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rready  <= 1'b0;
            r_out     <= '0;
            r_discard <= '0;
            r_resp_pc <= RESET_PC;
        end else begin
            r_rready <= 1'b1;
            r_out    <= w_out_next;
            if (is_branch) begin
                r_discard <= w_out_next + CW'(r_arvalid && !ARREADY);
                r_resp_pc <= w_tgt;
            end else begin
                if (w_r_hs && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + ADDR_WIDTH'(4);
                end
            end
        end
    end

    // Buffer pointers; a branch empties the buffer outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (is_branch) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (PW+1)'(1);
        end
    end

    // Buffer storage needs no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[w_widx] <= RDATA;
            r_mem_pc[w_widx]   <= r_resp_pc;
            r_mem_err[w_widx]  <= (RRESP != 2'b00);
        end
    end

    // Head of buffer, forced to zero when empty.
    always_comb begin
        instr     = '0;
        instr_pc  = '0;
        instr_err = 1'b0;
        if (instr_valid) begin
            instr     = INSTR_WIDTH'(r_mem_data[w_ridx]);
            instr_pc  = r_mem_pc[w_ridx];
            instr_err = r_mem_err[w_ridx];
        end
    end

endmodule

// File: tb/tb_core_prefetch_unit.sv
// Scoreboard bench for core_prefetch_unit with a small AXI-lite slave model.
// Expected words are queued at reset/branch and checked on every pop.
module tb_core_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_stall;
    logic        is_branch;
    logic [31:0] new_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_err;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    always #5 clk = ~clk;

    core_prefetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_stall (fetch_stall),
        .is_branch   (is_branch),
        .new_pc      (new_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_err   (instr_err),
        .ARADDR      (ARADDR),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RVALID      (RVALID),
        .RREADY      (RREADY)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rq[$];
    logic [31:0] ar_log[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          pops  = 0;
    bit          err_en = 1'b1;
    bit          rhold  = 1'b0;
    logic        ar_s = 1'b0;
    logic        r_s  = 1'b0;
    logic [31:0] ar_addr_s = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        return (wa * 32'h0001_0001) ^ 32'hA5A5_0000;
    endfunction

    function automatic void chk(input string name,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fill(input logic [31:0] pc);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            e.pc   = pc + 32'(4 * i);
            e.data = mem_word(e.pc >> 2);
            e.err  = err_en && (e.pc == 32'h4);
            exp_q.push_back(e);
        end
    endfunction

    // Slave: sample handshakes at negedge, answer one cycle after AR.
    always @(negedge clk) begin
        ar_s      = ARVALID && ARREADY;
        ar_addr_s = ARADDR;
        r_s       = RVALID && RREADY;
        if (ar_s) ar_log.push_back(ARADDR);
    end

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            rq.delete();
            RVALID = 1'b0;
            RDATA  = '0;
            RRESP  = 2'b00;
        end else begin
            if (r_s && rq.size() > 0) void'(rq.pop_front());
            if (ar_s) rq.push_back(ar_addr_s);
            if (rq.size() > 0 && !rhold) begin
                RVALID = 1'b1;
                RDATA  = mem_word(rq[0]);
                RRESP  = (err_en && rq[0] == 32'h1) ? 2'b10 : 2'b00;
            end else begin
                RVALID = 1'b0;
                RDATA  = '0;
                RRESP  = 2'b00;
            end
        end
    end

    // Monitor: every pop must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (instr_valid && !fetch_stall && !is_branch) begin
                if (exp_q.size() == 0) begin
                    chk("pop_underflow", 64'(instr_pc), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc",   64'(instr_pc),  64'(e.pc));
                    chk("pop_data", 64'(instr),     64'(e.data));
                    chk("pop_err",  64'(instr_err), 64'(e.err));
                    pops++;
                end
            end else if (!instr_valid) begin
                chk("bubble_instr", 64'(instr), 64'h0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic branch(input logic [31:0] pc, input logic [31:0] tgt);
        is_branch = 1'b1;
        new_pc    = pc;
        fill(tgt);
        step(1);
        is_branch = 1'b0;
        ar_log.delete();
    endtask

    initial begin
        int p0;
        bit found;
        rst = 1'b0; fetch_stall = 1'b0; is_branch = 1'b0;
        new_pc = '0; ARREADY = 1'b1;
        RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
        step(3);
        chk("rst_arvalid", 64'(ARVALID),     64'h0);
        chk("rst_rready",  64'(RREADY),      64'h0);
        chk("rst_valid",   64'(instr_valid), 64'h0);
        chk("rst_instr",   64'(instr),       64'h0);
        chk("rst_err",     64'(instr_err),   64'h0);

        // Sequential fetch from reset; second read returns SLVERR.
        fill(32'h0);
        rst = 1'b1;
        p0 = pops;
        step(16);
        chk("p1_ar0", 64'(ar_log[0]), 64'h0);
        chk("p1_ar1", 64'(ar_log[1]), 64'h1);
        chk("p1_ar2", 64'(ar_log[2]), 64'h2);
        chk("p1_ar3", 64'(ar_log[3]), 64'h3);
        chk("p1_pops", 64'(pops - p0 >= 4), 64'h1);

        // Stall fills exactly FIFO_DEPTH words, nothing beyond credit.
        fetch_stall = 1'b1;
        branch(32'h200, 32'h200);
        step(14);
        chk("st_ar_cnt", 64'(ar_log.size()), 64'd4);
        chk("st_ar0",    64'(ar_log[0]),     64'h80);
        chk("st_ar3",    64'(ar_log[3]),     64'h83);
        chk("st_arvalid", 64'(ARVALID),      64'h0);
        chk("st_valid",  64'(instr_valid),   64'h1);
        chk("st_head",   64'(instr_pc),      64'h200);
        fetch_stall = 1'b0;
        step(14);

        // Two reads held outstanding, then branch drops both.
        rhold = 1'b1;
        step(8);
        chk("os_arvalid", 64'(ARVALID), 64'h0);
        rhold = 1'b0;
        p0 = pops;
        branch(32'h100, 32'h100);
        step(14);
        chk("os_ar0",  64'(ar_log[0]),      64'h40);
        chk("os_pops", 64'(pops - p0 >= 3), 64'h1);

        // Pending AR held across a branch with ARREADY low.
        fetch_stall = 1'b1;
        branch(32'h300, 32'h300);
        step(14);
        ARREADY = 1'b0;
        fetch_stall = 1'b0;
        step(1);
        fetch_stall = 1'b1;
        step(3);
        chk("hd_arvalid0", 64'(ARVALID), 64'h1);
        chk("hd_araddr0",  64'(ARADDR),  64'hC4);
        branch(32'h100, 32'h100);
        step(2);
        chk("hd_arvalid1", 64'(ARVALID), 64'h1);
        chk("hd_araddr1",  64'(ARADDR),  64'hC4);
        ar_log.delete();
        ARREADY = 1'b1;
        fetch_stall = 1'b0;
        step(16);
        chk("hd_ar0", 64'(ar_log[0]), 64'hC4);
        chk("hd_ar1", 64'(ar_log[1]), 64'h40);

        // Branch in a cycle with a response and a pop together.
        fetch_stall = 1'b1;
        step(4);
        fetch_stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #3;
            if (RVALID && instr_valid) found = 1'b1;
        end
        chk("rb_found", 64'(found), 64'h1);
        is_branch = 1'b1;
        new_pc    = 32'h180;
        fill(32'h180);
        @(posedge clk);
        #1;
        is_branch = 1'b0;
        @(negedge clk);
        chk("rb_empty", 64'(instr_valid), 64'h0);
        step(16);

        // Misaligned target and PC wrap-around.
        err_en = 1'b0;
        branch(32'hFFFF_FFF6, 32'hFFFF_FFF4);
        step(20);
        chk("wr_ar0", 64'(ar_log[0]), 64'h3FFF_FFFD);
        chk("wr_ar2", 64'(ar_log[2]), 64'h3FFF_FFFF);
        chk("wr_ar3", 64'(ar_log[3]), 64'h0);

        // Asynchronous reset in mid-flight.
        #2;
        rst = 1'b0;
        #1;
        chk("ar_rst_arvalid", 64'(ARVALID),     64'h0);
        chk("ar_rst_valid",   64'(instr_valid), 64'h0);
        chk("ar_rst_rready",  64'(RREADY),      64'h0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
